fetch_sequencer: RTL

//  Fetch sequencer between the CPU core and the external program-memory byte bus.
//  It owns the program counter, fetches the opcode byte and, if needed, the immediate byte.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_pc.sv | 28 ++
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch definitions: FSM state encodings, opcode immediate-flag position and address width default.
package cpu_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int OP_IMM_BIT = 7;

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_OP_REQ  = 3'd1,
        FS_IMM_REQ = 3'd2,
        FS_HOLD    = 3'd3,
        FS_ERR     = 3'd4
    } fetch_state_e;

    // An opcode with its top bit set is followed by one immediate byte.
    function automatic logic has_imm(input logic [7:0] op);
        return op[OP_IMM_BIT];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: load on redirect, increment per fetched byte, natural ADDR_W-bit wrap.
module fetch_pc #(
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= load_pc_i;
        end else if (inc_i) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: requests opcode/immediate bytes over a req/ack bus and hands instructions to the core.
// Define FETCH_TIMEOUT_EN to add the ack-wait timeout counter and the sticky ERR state.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
`ifdef FETCH_TIMEOUT_EN
    parameter int                TIMEOUT  = 15,
`endif
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [7:0]        ins_op,
    output logic [7:0]        ins_imm,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    fetch_state_e      state_q;
    logic              mem_req_q;
    logic              ins_valid_q;
    logic [7:0]        ins_op_q;
    logic [7:0]        ins_imm_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [ADDR_W-1:0] pcCur;
    logic              redirTake;
    logic              byteAck;

    // A redirect abandons any request in flight, so its same-cycle ack must not advance the PC.
    assign redirTake = redirect && (state_q != FS_ERR);
    assign byteAck   = mem_req_q && mem_ack && !redirTake &&
                       ((state_q == FS_OP_REQ) || (state_q == FS_IMM_REQ));

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirTake),
        .load_pc_i (redirect_pc),
        .inc_i     (byteAck),
        .pc_o      (pcCur)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            mem_req_q   <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_op_q    <= 8'h00;
            ins_imm_q   <= 8'h00;
            pc_out_q    <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else if (redirTake) begin
            state_q     <= FS_OP_REQ;
            mem_req_q   <= 1'b0;
            ins_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            case (state_q)
                FS_IDLE: begin
                    state_q   <= FS_OP_REQ;
                    mem_req_q <= 1'b1;
                end
                // A request state entered with mem_req low spends one idle cycle before asking.
                FS_OP_REQ, FS_IMM_REQ: begin
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        wait_q    <= '0;
`endif
                        if (state_q == FS_OP_REQ) begin
                            ins_op_q <= mem_data;
                            pc_out_q <= pcCur;
                            if (has_imm(mem_data)) begin
                                state_q <= FS_IMM_REQ;
                            end else begin
                                ins_imm_q   <= 8'h00;
                                ins_valid_q <= 1'b1;
                                state_q     <= FS_HOLD;
                            end
                        end else begin
                            ins_imm_q   <= mem_data;
                            ins_valid_q <= 1'b1;
                            state_q     <= FS_HOLD;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q   <= FS_ERR;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        wait_q    <= '0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
`endif
                end
                FS_HOLD: begin
                    if (ins_ready) begin
                        ins_valid_q <= 1'b0;
                        mem_req_q   <= 1'b1;
                        state_q     <= FS_OP_REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = pcCur;
    assign ins_valid = ins_valid_q;
    assign ins_op    = ins_op_q;
    assign ins_imm   = ins_imm_q;
    assign pc_out    = pc_out_q;

endmodule
